i2c_codec_target: RTL

//  I2C write-only target (slave) modelling the WM8731 control port.

---
 rtl/i2c_codec_target.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/i2c_codec_target.sv
// Write-only I2C target modelling the WM8731 control port: decodes
// [dev addr+W][reg addr|data[8]][data[7:0]] and emits one register-write pulse.
module i2c_codec_target #(
    parameter logic [6:0] DEV_ADDR = 7'h1A
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i2c_sclk,
    inout  wire        i2c_sdat,
    output logic [6:0] reg_addr,
    output logic [8:0] reg_data,
    output logic       reg_valid,
    output logic       busy,
    output logic       err
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        IGNORE
    } state_t;

    state_t      state;
    logic        scl_s1, scl_s2, scl_h;
    logic        sda_s1, sda_s2, sda_h;
    logic        sda_low;
    logic [2:0]  bit_cnt;
    logic [1:0]  byte_cnt;
    logic [7:0]  sh;
    logic [7:0]  sh_next;
    logic [6:0]  addr_n;
    logic [8:0]  data_n;
    logic        scl_rise, scl_fall, start_det, stop_det;

    assign i2c_sdat = sda_low ? 1'b0 : 1'bz;
    assign busy     = (state != IDLE);

    assign scl_rise  = scl_s2 & ~scl_h;
    assign scl_fall  = ~scl_s2 & scl_h;
    assign start_det = scl_s2 & scl_h & sda_h & ~sda_s2;
    assign stop_det  = scl_s2 & scl_h & ~sda_h & sda_s2;
    assign sh_next   = {sh[6:0], sda_s2};

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            scl_h  <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            sda_h  <= 1'b1;
        end else begin
            scl_s1 <= i2c_sclk;
            scl_s2 <= scl_s1;
            scl_h  <= scl_s2;
            sda_s1 <= i2c_sdat;
            sda_s2 <= sda_s1;
            sda_h  <= sda_s2;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            sda_low   <= 1'b0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            sh        <= '0;
            addr_n    <= '0;
            data_n    <= '0;
            reg_addr  <= '0;
            reg_data  <= '0;
            reg_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            reg_valid <= 1'b0;
            err       <= 1'b0;
            if (start_det) begin
                state    <= ADDR;
                bit_cnt  <= '0;
                byte_cnt <= '0;
                sda_low  <= 1'b0;
            end else if (stop_det) begin
                state   <= IDLE;
                sda_low <= 1'b0;
                err     <= (byte_cnt == 2'd1);
            end else begin
                case (state)
                    IDLE: ;
                    ADDR: begin
                        if (scl_rise) begin
                            sh      <= sh_next;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7)
                                state <= (sh_next == {DEV_ADDR, 1'b0}) ? ADDR_ACK : IGNORE;
                        end
                    end
                    // sda_low doubles as the ACK phase: first SCL fall asserts, second releases
                    ADDR_ACK, DATA_ACK: begin
                        if (scl_fall) begin
                            if (!sda_low) begin
                                sda_low <= 1'b1;
                            end else begin
                                sda_low <= 1'b0;
                                state   <= DATA;
                                if (state == DATA_ACK && byte_cnt == 2'd2) begin
                                    reg_addr  <= addr_n;
                                    reg_data  <= data_n;
                                    reg_valid <= 1'b1;
                                end
                            end
                        end
                    end
                    DATA: begin
                        if (scl_rise) begin
                            sh      <= sh_next;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (byte_cnt == 2'd0) begin
                                    addr_n    <= sh_next[7:1];
                                    data_n[8] <= sh_next[0];
                                    byte_cnt  <= 2'd1;
                                    state     <= DATA_ACK;
                                end else if (byte_cnt == 2'd1) begin
                                    data_n[7:0] <= sh_next;
                                    byte_cnt    <= 2'd2;
                                    state       <= DATA_ACK;
                                end else begin
                                    err   <= 1'b1;
                                    state <= IGNORE;
                                end
                            end
                        end
                    end
                    IGNORE: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
